// File: rtl/danger_pos_gen_pkg.sv
// Shared screen/obstacle constants and FSM encoding for the obstacle position generator.
package danger_pos_gen_pkg;

  localparam int SCREEN_W      = 320;
  localparam int GROUND        = 200;
  localparam int DANGER1_WIDTH = 26;
  localparam int DANGER1_H     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  // A speed of zero would freeze the obstacle forever, so it scrolls at 1.
  function automatic logic [3:0] eff_step(input logic [3:0] speed);
    return (speed == 4'd0) ? 4'd1 : speed;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left; advances when en is high.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] q
);

  logic fb;
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (rst)     q <= SEED;
    else if (en) q <= {q[6:0], fb};
  end

endmodule

// File: rtl/danger_pos_gen.sv
// Obstacle spawn/scroll/retire FSM; all state moves only on frame_tick & run, i.e. during blanking.
module danger_pos_gen
  import danger_pos_gen_pkg::*;
#(
  parameter logic [8:0] SPAWN_POS = 9'(SCREEN_W + DANGER1_WIDTH),
  parameter logic [7:0] MIN_GAP   = 8'd16,
  parameter logic [7:0] GAP_MASK  = 8'h3F,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [3:0] speed,
  output logic [8:0] pos,
  output logic       active,
  output logic       passed,
  output logic [1:0] state_dbg
);

  state_t     state, state_nxt;
  logic [8:0] pos_nxt;
  logic       active_nxt, passed_nxt;
  logic [7:0] gap_cnt, gap_nxt, gap_load, lfsr_q;
  logic [3:0] step;
  logic       evt;

  assign evt      = frame_tick & run;
  assign step     = eff_step(speed);
  // Gap is drawn from the LFSR value before this event's advance.
  assign gap_load = MIN_GAP + (lfsr_q & GAP_MASK);

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (evt),
    .q   (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pos     <= '0;
      active  <= 1'b0;
      passed  <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pos     <= pos_nxt;
      active  <= active_nxt;
      passed  <= passed_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pos_nxt    = pos;
    active_nxt = active;
    passed_nxt = 1'b0;
    gap_nxt    = gap_cnt;
    if (evt) begin
      case (state)
        ST_IDLE: begin
          gap_nxt   = gap_load;
          state_nxt = ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) begin
            pos_nxt    = SPAWN_POS;
            active_nxt = 1'b1;
            state_nxt  = ST_SCROLL;
          end else begin
            gap_nxt = gap_cnt - 8'd1;
          end
        end
        ST_SCROLL: begin
          // Clamp at zero: the last partial step retires rather than wraps.
          if (pos <= {5'd0, step}) begin
            pos_nxt    = '0;
            active_nxt = 1'b0;
            passed_nxt = 1'b1;
            gap_nxt    = gap_load;
            state_nxt  = ST_GAP;
          end else begin
            pos_nxt = pos - {5'd0, step};
          end
        end
        default: begin
          pos_nxt    = '0;
          active_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_danger_pos_gen.sv
// Scoreboard bench: two instances (no random gap / default random gap) share stimulus.
module tb_danger_pos_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic [3:0] speed = 4'd4;

  logic [8:0] pos_a, pos_b;
  logic       act_a, act_b, pass_a, pass_b;
  logic [1:0] st_a, st_b;

  always #5 clk = ~clk;

  danger_pos_gen #(.GAP_MASK(8'h00)) dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .speed(speed),
    .pos(pos_a), .active(act_a), .passed(pass_a), .state_dbg(st_a)
  );

  danger_pos_gen dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .speed(speed),
    .pos(pos_b), .active(act_b), .passed(pass_b), .state_dbg(st_b)
  );

  typedef struct {
    int st, pos, gap, lfsr, act, pass;
  } mdl_t;

  typedef struct {
    string tag;
    int a_pos, a_act, a_pass, a_st;
    int b_pos, b_act, b_pass, b_st;
    int h_on, h_dut, h_pos, h_act, h_st;
  } exp_t;

  exp_t exp_q[$];
  mdl_t ma, mb;
  int   n_vec = 0;
  int   n_err = 0;
  int   tn = 0;
  logic tick_q = 1'b0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    tick_q <= frame_tick;
    rst_q  <= rst;
  end

  function automatic int lfsr_nx(input int x);
    int fb;
    fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
    return ((x << 1) | fb) & 255;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = 0; m.pos = 0; m.gap = 0; m.lfsr = 'hA5; m.act = 0; m.pass = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int mask, input int spd, input bit go);
    int s;
    s = (spd == 0) ? 1 : spd;
    m.pass = 0;
    if (!go) return m;
    if (m.st == 0) begin
      m.gap = 16 + (m.lfsr & mask);
      m.st  = 1;
    end else if (m.st == 1) begin
      if (m.gap == 0) begin
        m.pos = 346; m.act = 1; m.st = 2;
      end else m.gap--;
    end else begin
      if (m.pos <= s) begin
        m.pos = 0; m.act = 0; m.pass = 1; m.st = 1;
        m.gap = 16 + (m.lfsr & mask);
      end else m.pos -= s;
    end
    m.lfsr = lfsr_nx(m.lfsr);
    return m;
  endfunction

  function automatic exp_t mk(input string tag, input int hon, input int hd,
                              input int hp, input int ha, input int hs);
    exp_t e;
    e.tag = tag;
    e.a_pos = ma.pos; e.a_act = ma.act; e.a_pass = ma.pass; e.a_st = ma.st;
    e.b_pos = mb.pos; e.b_act = mb.act; e.b_pass = mb.pass; e.b_st = mb.st;
    e.h_on = hon; e.h_dut = hd; e.h_pos = hp; e.h_act = ha; e.h_st = hs;
    return e;
  endfunction

  function automatic void cmp(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endfunction

  // Monitor: one response per sampled tick or reset, plus passed-clear one cycle later.
  initial begin
    exp_t e;
    bit   pend_clr;
    pend_clr = 0;
    forever begin
      @(negedge clk);
      if (pend_clr) begin
        pend_clr = 0;
        cmp({e.tag, " a.passed_clear"}, int'(pass_a), 0);
        cmp({e.tag, " b.passed_clear"}, int'(pass_b), 0);
      end
      if (tick_q || rst_q) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard_empty: got response with no expected entry");
        end else begin
          e = exp_q.pop_front();
          cmp({e.tag, " a.pos"},    int'(pos_a),  e.a_pos);
          cmp({e.tag, " a.active"}, int'(act_a),  e.a_act);
          cmp({e.tag, " a.passed"}, int'(pass_a), e.a_pass);
          cmp({e.tag, " a.state"},  int'(st_a),   e.a_st);
          cmp({e.tag, " b.pos"},    int'(pos_b),  e.b_pos);
          cmp({e.tag, " b.active"}, int'(act_b),  e.b_act);
          cmp({e.tag, " b.passed"}, int'(pass_b), e.b_pass);
          cmp({e.tag, " b.state"},  int'(st_b),   e.b_st);
          if (e.h_on != 0) begin
            cmp({e.tag, " hand.pos"},    e.h_dut ? int'(pos_b) : int'(pos_a), e.h_pos);
            cmp({e.tag, " hand.active"}, e.h_dut ? int'(act_b) : int'(act_a), e.h_act);
            cmp({e.tag, " hand.state"},  e.h_dut ? int'(st_b)  : int'(st_a),  e.h_st);
          end
          pend_clr = 1;
        end
      end
    end
  end

  task automatic tickh(input int hon, input int hd, input int hp, input int ha, input int hs);
    @(negedge clk);
    frame_tick = 1'b1;
    tn++;
    ma = mstep(ma, 'h00, int'(speed), run);
    mb = mstep(mb, 'h3F, int'(speed), run);
    exp_q.push_back(mk($sformatf("tick%0d", tn), hon, hd, hp, ha, hs));
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic tick();
    tickh(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    ma = mreset();
    mb = mreset();
    tn = 0;
    exp_q.push_back(mk(tag, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Spawn/scroll/retire at speed 4; b shows the 53-frame first gap.
    run = 1'b1; speed = 4'd4;
    for (int n = 1; n <= 105; n++) begin
      case (n)
        1:       tickh(1, 0, 0,   0, 1);
        18:      tickh(1, 0, 346, 1, 2);
        19:      tickh(1, 0, 342, 1, 2);
        54:      tickh(1, 1, 0,   0, 1);
        55:      tickh(1, 1, 346, 1, 2);
        104:     tickh(1, 0, 2,   1, 2);
        105:     tickh(1, 0, 0,   0, 1);
        default: tick();
      endcase
    end

    // Speed 0 scrolls one pixel per frame; a spawns at tick 122 and retires at 468.
    speed = 4'd0;
    for (int n = 106; n <= 468; n++) begin
      case (n)
        122:     tickh(1, 0, 346, 1, 2);
        123:     tickh(1, 0, 345, 1, 2);
        467:     tickh(1, 0, 1,   1, 2);
        468:     tickh(1, 0, 0,   0, 1);
        default: tick();
      endcase
    end

    // Speed 2 brings a to pos 200 at tick 558, then pause.
    speed = 4'd2;
    for (int n = 469; n <= 558; n++) begin
      if (n == 485)      tickh(1, 0, 346, 1, 2);
      else if (n == 558) tickh(1, 0, 200, 1, 2);
      else               tick();
    end
    run = 1'b0;
    for (int n = 0; n < 5; n++) tickh(1, 0, 200, 1, 2);
    run = 1'b1; speed = 4'd4;
    tickh(1, 0, 196, 1, 2);

    // Reset mid-scroll at pos 150 drops the obstacle and reseeds the LFSR.
    speed = 4'd2;
    for (int n = 0; n < 23; n++) begin
      if (n == 22) tickh(1, 0, 150, 1, 2);
      else         tick();
    end
    do_reset("midscroll_reset");

    // After reseed, b's first gap is again 53 frames.
    speed = 4'd3;
    for (int n = 1; n <= 70; n++) begin
      case (n)
        1:       tickh(1, 1, 0,   0, 1);
        18:      tickh(1, 0, 346, 1, 2);
        55:      tickh(1, 1, 346, 1, 2);
        56:      tickh(1, 1, 343, 1, 2);
        default: tick();
      endcase
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
